// File: rtl/snitch_perf_counter_unit.sv
// Cluster performance counters: each counter picks one hart/event strobe from the
// registered core event vectors and counts it; accessed via a single-cycle register port.
module snitch_perf_counter_unit #(
  parameter int unsigned NumCores     = 8,
  parameter int unsigned NumCounters  = 16,
  parameter int unsigned CounterWidth = 48
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumCores-1:0][6:0] core_events_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [7:0]               req_addr_i,
  input  logic                     req_write_i,
  input  logic [31:0]              req_wdata_i,
  output logic                     rsp_valid_o,
  output logic [31:0]              rsp_rdata_o,
  output logic                     rsp_error_o
);

  localparam int unsigned HiWidth = CounterWidth - 32;

  typedef enum logic [1:0] {
    RegCfg   = 2'd0,
    RegCntLo = 2'd1,
    RegCntHi = 2'd2,
    RegRsvd  = 2'd3
  } reg_sel_e;

  logic [NumCores-1:0][6:0] events_q;
  logic [CounterWidth-1:0]  cnt_q   [NumCounters];
  logic [CounterWidth-1:0]  cnt_d   [NumCounters];
  logic [NumCounters-1:0]   en_q, en_d, ovf_q, ovf_d;
  logic [2:0]               evsel_q [NumCounters];
  logic [2:0]               evsel_d [NumCounters];
  logic [7:0]               hart_q  [NumCounters];
  logic [7:0]               hart_d  [NumCounters];
  logic [NumCounters-1:0]   hit, inc, cfg_wr, cnt_wr;

  logic [3:0]  idx;
  reg_sel_e    sel;
  logic        addr_err, wr_ok;
  logic [31:0] rdata;

  assign idx         = req_addr_i[7:4];
  assign sel         = reg_sel_e'(req_addr_i[3:2]);
  assign addr_err    = (req_addr_i[1:0] != 2'b00) || (32'(idx) >= NumCounters) || (sel == RegRsvd);
  assign wr_ok       = req_valid_i && req_write_i && !addr_err;
  assign req_ready_o = 1'b1;

  // Matching hart and event by loop keeps out-of-range selects naturally inert.
  always_comb begin
    hit    = '0;
    cfg_wr = '0;
    cnt_wr = '0;
    for (int unsigned i = 0; i < NumCounters; i++) begin
      for (int unsigned c = 0; c < NumCores; c++) begin
        for (int unsigned e = 0; e < 7; e++) begin
          if (hart_q[i] == 8'(c) && evsel_q[i] == 3'(e) && events_q[c][e]) hit[i] = 1'b1;
        end
      end
      cfg_wr[i] = wr_ok && (idx == 4'(i)) && (sel == RegCfg);
      cnt_wr[i] = wr_ok && (idx == 4'(i)) && (sel == RegCntLo || sel == RegCntHi);
    end
    inc = en_q & hit;
  end

  always_comb begin
    for (int unsigned i = 0; i < NumCounters; i++) begin
      cnt_d[i]   = cnt_q[i];
      en_d[i]    = en_q[i];
      evsel_d[i] = evsel_q[i];
      hart_d[i]  = hart_q[i];
      ovf_d[i]   = ovf_q[i] && !(cfg_wr[i] && req_wdata_i[1]);
      if (cfg_wr[i]) begin
        en_d[i]    = req_wdata_i[0];
        evsel_d[i] = req_wdata_i[6:4];
        hart_d[i]  = req_wdata_i[15:8];
      end
      // A software write to either half drops the same-edge increment.
      if (cnt_wr[i]) begin
        if (sel == RegCntLo) cnt_d[i][31:0] = req_wdata_i;
        else                 cnt_d[i][CounterWidth-1:32] = req_wdata_i[HiWidth-1:0];
      end else if (inc[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
        if (&cnt_q[i]) ovf_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NumCounters; i++) begin
      if (idx == 4'(i)) begin
        case (sel)
          RegCfg:   rdata = {16'h0, hart_q[i], 1'b0, evsel_q[i], 2'b00, ovf_q[i], en_q[i]};
          RegCntLo: rdata = cnt_q[i][31:0];
          RegCntHi: rdata[HiWidth-1:0] = cnt_q[i][CounterWidth-1:32];
          default:  rdata = '0;
        endcase
      end
    end
    if (addr_err || req_write_i) rdata = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      events_q    <= '0;
      en_q        <= '0;
      ovf_q       <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
      for (int unsigned i = 0; i < NumCounters; i++) begin
        cnt_q[i]   <= '0;
        evsel_q[i] <= '0;
        hart_q[i]  <= '0;
      end
    end else begin
      events_q    <= core_events_i;
      en_q        <= en_d;
      ovf_q       <= ovf_d;
      rsp_valid_o <= req_valid_i;
      rsp_rdata_o <= req_valid_i ? rdata : '0;
      rsp_error_o <= req_valid_i && addr_err;
      for (int unsigned i = 0; i < NumCounters; i++) begin
        cnt_q[i]   <= cnt_d[i];
        evsel_q[i] <= evsel_d[i];
        hart_q[i]  <= hart_d[i];
      end
    end
  end

endmodule

// File: tb/tb_snitch_perf_counter_unit.sv
// Scoreboard bench for snitch_perf_counter_unit: an arithmetic reference model predicts
// every response; a negedge monitor pops and compares.
module tb_snitch_perf_counter_unit;

  localparam int NC = 8;
  localparam int NK = 16;
  localparam longint unsigned CMAX = (64'd1 << 48) - 1;
  localparam longint unsigned LO_SPAN = 64'd1 << 32;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic [NC-1:0][6:0]  core_events_i;
  logic                req_valid_i, req_ready_o, req_write_i;
  logic [7:0]          req_addr_i;
  logic [31:0]         req_wdata_i;
  logic                rsp_valid_o, rsp_error_o;
  logic [31:0]         rsp_rdata_o;

  snitch_perf_counter_unit #(.NumCores(NC), .NumCounters(NK), .CounterWidth(48)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .core_events_i(core_events_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_write_i(req_write_i), .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;

  longint unsigned m_cnt [NK];
  bit              m_en  [NK];
  bit              m_ovf [NK];
  int unsigned     m_sel [NK];
  int unsigned     m_hart[NK];
  bit              ev_prev[NC][7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NK; i++) begin
      m_cnt[i] = 0; m_en[i] = 0; m_ovf[i] = 0; m_sel[i] = 0; m_hart[i] = 0;
    end
    for (int c = 0; c < NC; c++)
      for (int e = 0; e < 7; e++) ev_prev[c][e] = 0;
  endtask

  function automatic exp_t model_read(input bit [7:0] a, input bit w);
    int unsigned idx = a / 16;
    int unsigned off = a % 16;
    exp_t r;
    r.rdata = 0;
    r.err   = 0;
    if (a % 4 != 0 || idx >= NK || off == 12) r.err = 1;
    else if (!w) begin
      case (off)
        0:       r.rdata = 32'(m_hart[idx] * 256 + m_sel[idx] * 16 + m_ovf[idx] * 2 + m_en[idx]);
        4:       r.rdata = 32'(m_cnt[idx] % LO_SPAN);
        default: r.rdata = 32'(m_cnt[idx] / LO_SPAN);
      endcase
    end
    return r;
  endfunction

  // Called just after each rising edge with the inputs the DUT sampled at that edge.
  task automatic model_edge();
    exp_t r;
    bit inc[NK];
    bit wr;
    int unsigned idx, off;
    longint unsigned d;
    r   = model_read(req_addr_i, req_write_i);
    if (req_valid_i) exp_q.push_back(r);
    wr  = req_valid_i && req_write_i && !r.err;
    idx = req_addr_i / 16;
    off = req_addr_i % 16;
    d   = req_wdata_i;
    for (int i = 0; i < NK; i++)
      inc[i] = m_en[i] && m_hart[i] < NC && m_sel[i] <= 6 && ev_prev[m_hart[i]][m_sel[i]];
    for (int i = 0; i < NK; i++) begin
      if (wr && idx == i && off == 0) begin
        m_en[i]   = d[0];
        m_sel[i]  = (d / 16) % 8;
        m_hart[i] = (d / 256) % 256;
        if (d[1]) m_ovf[i] = 0;
      end
      if (wr && idx == i && off == 4)
        m_cnt[i] = m_cnt[i] - m_cnt[i] % LO_SPAN + d;
      else if (wr && idx == i && off == 8)
        m_cnt[i] = (d % 65536) * LO_SPAN + m_cnt[i] % LO_SPAN;
      else if (inc[i]) begin
        if (m_cnt[i] == CMAX) begin
          m_cnt[i] = 0;
          m_ovf[i] = 1;
        end else m_cnt[i] = m_cnt[i] + 1;
      end
    end
    for (int c = 0; c < NC; c++)
      for (int e = 0; e < 7; e++) ev_prev[c][e] = core_events_i[c][e];
  endtask

  task automatic step(input bit v, input bit w, input bit [7:0] a, input bit [31:0] d);
    req_valid_i = v; req_write_i = w; req_addr_i = a; req_wdata_i = d;
    @(posedge clk_i);
    model_edge();
    #1;
    req_valid_i = 0; req_write_i = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 8'h00, 0);
  endtask

  task automatic rd(input bit [7:0] a);
    step(1, 0, a, 0);
  endtask

  task automatic wr(input bit [7:0] a, input bit [31:0] d);
    step(1, 1, a, d);
  endtask

  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("rsp_valid", rsp_valid_o, 1);
        check("rsp_rdata", rsp_rdata_o, mon_e.rdata);
        check("rsp_error", rsp_error_o, mon_e.err);
        check("req_ready", req_ready_o, 1);
      end else begin
        check("rsp_spurious", rsp_valid_o, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned idx, off, ahi;
    bit [7:0]    a;
    bit [31:0]   d;
    rst_ni = 1; core_events_i = '0;
    req_valid_i = 0; req_write_i = 0; req_addr_i = 0; req_wdata_i = 0;
    model_reset();
    #2 rst_ni = 0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_rsp_valid", rsp_valid_o, 0);
    check("reset_rsp_rdata", rsp_rdata_o, 0);
    check("reset_rsp_error", rsp_error_o, 0);
    rst_ni = 1;

    rd(8'h04); rd(8'h08); rd(8'h00);

    // hart 3 retired_acc for 10 cycles; hart 2 busy throughout
    wr(8'h00, 32'h0301);
    core_events_i[2] = '1;
    core_events_i[3][0] = 1;
    idle(10);
    core_events_i[3][0] = 0;
    idle(2);
    rd(8'h04); rd(8'h08); rd(8'h00);

    // wrap on counter 1 with sticky overflow and W1C
    wr(8'h18, 32'hFFFF); wr(8'h14, 32'hFFFF_FFFE); wr(8'h10, 32'h0301);
    core_events_i[3][0] = 1; idle(3); core_events_i[3][0] = 0; idle(2);
    rd(8'h14); rd(8'h18); rd(8'h10);
    wr(8'h10, 32'h0303); rd(8'h10);
    core_events_i[3][0] = 1; idle(2); core_events_i[3][0] = 0; idle(2);
    rd(8'h14); rd(8'h10);

    // software write collides with a due increment
    core_events_i[3][0] = 1; idle(1); core_events_i[3][0] = 0;
    wr(8'h04, 32'h100); idle(2);
    rd(8'h04); rd(8'h14);

    // invalid selects never count; error responses
    wr(8'h20, 32'h0071); wr(8'h30, 32'hC801);
    core_events_i = '1; idle(50); core_events_i = '0; idle(2);
    rd(8'h24); rd(8'h34); rd(8'h20); rd(8'h30);
    rd(8'hFC); rd(8'h02); wr(8'h0C, 32'h5); wr(8'h01, 32'hFFFF); rd(8'h00); rd(8'h04);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < NC; c++)
        for (int e = 0; e < 7; e++) core_events_i[c][e] = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) < 6) begin
        idx = $urandom_range(0, NK - 1);
        off = 4 * $urandom_range(0, 3);
        a   = 8'(idx * 16 + off);
        if ($urandom_range(0, 19) == 0) a = a + 8'($urandom_range(1, 3));
        if ($urandom_range(0, 9) < 4) begin
          ahi = $urandom_range(0, 3);
          case (off)
            0:       d = 32'($urandom_range(0, 9) * 256 + $urandom_range(0, 7) * 16
                         + $urandom_range(0, 1) * 2 + ($urandom_range(0, 4) != 0));
            8:       d = (ahi == 0) ? 32'hFFFF : $urandom;
            default: d = (ahi == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
          endcase
          wr(a, d);
        end else rd(a);
      end else idle(1);
    end
    core_events_i = '0;
    idle(2);
    for (int i = 0; i < NK; i++) begin
      rd(8'(i * 16)); rd(8'(i * 16 + 4)); rd(8'(i * 16 + 8));
    end

    // asynchronous reset between edges while counting
    wr(8'h00, 32'h0301); core_events_i = '1; idle(3);
    rd(8'h04);
    #2 rst_ni = 0;
    #1;
    check("async_rst_rsp_valid", rsp_valid_o, 0);
    check("async_rst_rsp_rdata", rsp_rdata_o, 0);
    check("async_rst_rsp_error", rsp_error_o, 0);
    exp_q.delete();
    model_reset();
    #2 rst_ni = 1;
    idle(10);
    rd(8'h04); rd(8'h00); rd(8'h14); rd(8'h10);
    wr(8'h00, 32'h0301); idle(5); core_events_i = '0; idle(2);
    rd(8'h04); rd(8'h08);

    idle(3);
    check("rsp_queue_drained", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
